// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: pipeline stage register with a valid/ready handshake,
// synchronous flush and a saturating stall counter.
// Optional feature macro: PIPE_SKID_EN adds a skid entry (two held payloads)
// and makes InReady a registered decode with no path from OutReady.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | nothing held, OutData = BUBBLE
// ST_ONE   | main register holds the payload on OutData
// ST_TWO   | main and skid both full, InReady low (skid only)
module pipe_stage_hs #(
  parameter int               WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter int               CNT_W  = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic [1:0]       Occupancy,
  output logic [CNT_W-1:0] StallCnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             in_ready;
  logic             accept;
  logic             emit;

`ifdef PIPE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;

  // InReady comes straight from a flop so upstream never sees OutReady
  assign in_ready = in_ready_q;
`else
  // Without a skid slot the stage can only take a payload if it frees one
  assign in_ready = (state_q == ST_EMPTY) | OutReady;
`endif

  assign OutValid  = (state_q != ST_EMPTY);
  assign OutData   = OutValid ? main_q : BUBBLE;
  assign Occupancy = 2'(state_q);
  assign InReady   = in_ready;
  assign StallCnt  = stall_cnt_q;

  // A flush cancels both transfers so no payload is counted as taken
  assign accept = InValid & in_ready & ~Flush;
  assign emit   = OutValid & OutReady & ~Flush;

  // Next-state and datapath selection
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_SKID_EN
    skid_d  = skid_q;
`endif
    if (Flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
`ifdef PIPE_SKID_EN
      skid_d  = '0;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = InData;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_d = InData;
`ifdef PIPE_SKID_EN
          end else if (accept) begin
            state_d = ST_TWO;
            skid_d  = InData;
`endif
          end else if (emit) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
          end
        end
        ST_TWO: begin
`ifdef PIPE_SKID_EN
          if (emit) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
`else
          // unreachable without a skid entry; recover to a clean empty stage
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
`endif
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
        end
      endcase
    end
  end

  // State and main payload register
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

`ifdef PIPE_SKID_EN
  // Skid payload and registered ready decode of the next state
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end
`endif

  // Saturating count of cycles a valid payload waited on downstream
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
    end else if (OutValid && !OutReady && !Flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: scoreboard bench for pipe_stage_hs. Works for both
// builds (PIPE_SKID_EN defined or not).
module tb_pipe_stage_hs;

  localparam int         WIDTH  = 8;
  localparam logic [7:0] BUBBLE = 8'hEE;
  localparam int         CNT_W  = 2;

  logic             clk = 1'b0;
  logic             Rst_n, Flush, InValid, InReady, OutValid, OutReady;
  logic [WIDTH-1:0] InData, OutData;
  logic [1:0]       Occupancy;
  logic [CNT_W-1:0] StallCnt;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] sb[$];
  int               m_cnt = 0;
  bit               known = 1'b0;

  pipe_stage_hs #(.WIDTH(WIDTH), .BUBBLE(BUBBLE), .CNT_W(CNT_W)) dut (
    .Clk(clk), .Rst_n(Rst_n), .Flush(Flush),
    .InValid(InValid), .InReady(InReady), .InData(InData),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .Occupancy(Occupancy), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check outputs against the queue model, advance
  task automatic step(input logic rst_n, input logic fl, input logic iv,
                      input logic [WIDTH-1:0] id, input logic ord);
    logic exp_valid, exp_rdy, acc, emi;
    @(negedge clk);
    Rst_n = rst_n; Flush = fl; InValid = iv; InData = id; OutReady = ord;
    #1;
    exp_valid = (sb.size() != 0);
`ifdef PIPE_SKID_EN
    exp_rdy = (sb.size() < 2);
`else
    exp_rdy = (sb.size() == 0) || ord;
`endif
    acc = rst_n && !fl && iv && exp_rdy;
    emi = rst_n && !fl && exp_valid && ord;
    if (known) begin
      chk_val("out_valid", 32'(OutValid), 32'(exp_valid));
      chk_val("out_data", 32'(OutData), exp_valid ? 32'(sb[0]) : 32'(BUBBLE));
      chk_val("occupancy", 32'(Occupancy), 32'(sb.size()));
      chk_val("in_ready", 32'(InReady), 32'(exp_rdy));
      chk_val("stall_cnt", 32'(StallCnt), 32'(m_cnt));
    end
    if (known && emi) chk_val("emit_data", 32'(OutData), 32'(sb[0]));
    @(posedge clk);
    if (!rst_n) begin
      sb.delete();
      m_cnt = 0;
      known = 1'b1;
    end else if (known) begin
      if (!fl && exp_valid && !ord && m_cnt != 3) m_cnt++;
      if (fl) sb.delete();
      else begin
        if (emi) void'(sb.pop_front());
        if (acc) sb.push_back(id);
      end
    end
  endtask

  initial begin
    Rst_n = 1'b0; Flush = 1'b0; InValid = 1'b0; InData = '0; OutReady = 1'b0;

    // reset with a payload offered: nothing may be captured
    step(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);

    // streaming at full throughput
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b1, 8'(i), 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // stall counter saturation, then flush keeps the count
    step(1'b1, 1'b0, 1'b1, 8'h30, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // back-pressure then release, order preserved
    step(1'b1, 1'b0, 1'b1, 8'h10, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h12, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // flush while full with a new payload offered: 0x55 must vanish
    step(1'b1, 1'b0, 1'b1, 8'h20, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h21, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h55, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // full stage, then OutReady raised in the same cycle a payload is offered
    step(1'b1, 1'b0, 1'b1, 8'h40, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h41, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h42, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // random traffic with occasional flush
    for (int i = 0; i < 300; i++)
      step(1'b1, ($urandom_range(15) == 0), 1'($urandom_range(1)),
           8'($urandom_range(255)), 1'($urandom_range(1)));

    // reset mid-stream discards held payloads
    step(1'b1, 1'b0, 1'b1, 8'h61, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h62, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h63, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'h64, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
